// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
// Holds the FSM encoding, the iteration count and the partial-result payload.
package muldiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 6;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [XLEN-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    DONE     = 3'd3,
    DZERO    = 3'd4
  } state_e;

  // Working register: hi is one bit wider so Booth add/sub and the shifted
  // remainder never overflow; q is the Booth "previous multiplier bit".
  typedef struct packed {
    logic [XLEN:0]   hi;
    logic [XLEN-1:0] lo;
    logic            q;
  } acc_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  // Unsigned magnitude; INT_MIN maps to 0x80000000, which is exact as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? negate(v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: radix-2 Booth add/shift for multiply,
// restoring shift/subtract for divide on magnitudes. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            div_i,
  input  acc_t            acc_i,
  input  logic [XLEN-1:0] opnd_i,
  output acc_t            acc_o
);

  logic [XLEN:0] opnd_sx;
  logic [XLEN:0] booth_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] rem_diff;

  always_comb begin
    opnd_sx   = {opnd_i[XLEN-1], opnd_i};
    booth_sum = acc_i.hi;
    case ({acc_i.lo[0], acc_i.q})
      2'b01:   booth_sum = acc_i.hi + opnd_sx;
      2'b10:   booth_sum = acc_i.hi - opnd_sx;
      default: booth_sum = acc_i.hi;
    endcase

    // Remainder shifted left by one, pulling in the next dividend bit.
    rem_sh   = {acc_i.hi[XLEN-1:0], acc_i.lo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd_i};

    acc_o = acc_i;
    if (div_i) begin
      acc_o.q = 1'b0;
      if (!rem_diff[XLEN]) begin
        acc_o.hi = rem_diff;
        acc_o.lo = {acc_i.lo[XLEN-2:0], 1'b1};
      end else begin
        acc_o.hi = rem_sh;
        acc_o.lo = {acc_i.lo[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o.hi = {booth_sum[XLEN], booth_sum[XLEN:1]};
      acc_o.lo = {booth_sum[0], acc_i.lo[XLEN-1:1]};
      acc_o.q  = acc_i.lo[0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequential signed multiply/divide unit with a fixed 33-cycle latency.
// Owns the FSM, iteration counter, operand/accumulator registers and HI/LO strobes.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_mult,
  input  logic            start_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            hi_we,
  output logic            lo_we
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prime_q, prime_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  acc_t              acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  muldiv_step u_step (
    .div_i  (state_q == DIV_RUN),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // Next-state, datapath and strobe logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prime_d = 1'b0;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start_mult || (start_div && (op_b != '0))) begin
          state_d  = start_mult ? MULT_RUN : DIV_RUN;
          cnt_d    = '0;
          prime_d  = 1'b1;
          acc_d.hi = '0;
          acc_d.lo = op_a;
          acc_d.q  = 1'b0;
          opnd_d   = op_b;
        end else if (start_div) begin
          state_d = DZERO;
        end
      end

      MULT_RUN, DIV_RUN: begin
        // First run cycle conditions the latched operands; steps follow.
        if (prime_q) begin
          if (state_q == DIV_RUN) begin
            neg_a_d  = acc_q.lo[XLEN-1];
            neg_b_d  = opnd_q[XLEN-1];
            acc_d.lo = mag(acc_q.lo);
            opnd_d   = mag(opnd_q);
          end
        end else begin
          acc_d = acc_step;
          if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
            state_d = DONE;
            if (state_q == MULT_RUN) begin
              hi_d = acc_step.hi[XLEN-1:0];
              lo_d = acc_step.lo;
            end else begin
              lo_d = (neg_a_q ^ neg_b_q) ? negate(acc_step.lo) : acc_step.lo;
              hi_d = neg_a_q ? negate(acc_step.hi[XLEN-1:0]) : acc_step.hi[XLEN-1:0];
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE, DZERO: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    dz_d   = (state_d == DZERO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prime_q <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign hi_we    = done_q;
  assign lo_we    = done_q;

endmodule
